// File: rtl/trace_pkg.sv
// Shared types for the commit-trace aligner: memory width encoding, queued retire
// record layout and the default reset PC.
package trace_pkg;

    // Access width in bits (8/16/32/64 all fit the 7-bit trace field).
    typedef logic [6:0] mem_width_t;

    localparam mem_width_t MW_BYTE  = 7'd8;
    localparam mem_width_t MW_HALF  = 7'd16;
    localparam mem_width_t MW_WORD  = 7'd32;
    localparam mem_width_t MW_DWORD = 7'd64;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        is_load;
        logic        is_store;
        logic [31:0] mem_addr;
        mem_width_t  mem_width;
        logic [31:0] store_data;
        logic [31:0] mem_data;
        logic        trap;
        logic [31:0] trap_cause;
        logic        data_ok;
    } retire_entry_t;

    // A trapping load never produces a bus response, so only clean loads wait.
    function automatic logic waits_for_load(input retire_entry_t e);
        return e.is_load && !e.trap;
    endfunction

endpackage

// File: rtl/trace_retire_fifo.sv
// Retire queue: entry storage, head/tail pointers, occupancy, and routing of
// in-order load responses to the oldest entry still waiting for data.
module trace_retire_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  retire_entry_t push_entry_i,
    input  logic          pop_i,
    input  logic          rsp_valid_i,
    input  logic [31:0]   rsp_mem_data_i,
    input  logic [31:0]   rsp_rd_data_i,
    output retire_entry_t head_entry_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          rsp_err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef logic [PW-1:0] ptr_t;

    retire_entry_t mem_q [DEPTH];
    ptr_t          head_q;
    ptr_t          tail_q;
    logic [PW:0]   count_q;
    ptr_t          load_ptr;
    logic          load_found;

    // Responses are in order, so the oldest occupied entry still missing data is the target.
    always_comb begin
        load_found = 1'b0;
        load_ptr   = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!load_found && (i < int'(count_q)) &&
                waits_for_load(mem_q[head_q + ptr_t'(i)]) &&
                !mem_q[head_q + ptr_t'(i)].data_ok) begin
                load_found = 1'b1;
                load_ptr   = head_q + ptr_t'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + 1'b1;
            if (pop_i)  head_q <= head_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) mem_q[tail_q] <= push_entry_i;
        if (rsp_valid_i && load_found) begin
            mem_q[load_ptr].mem_data <= rsp_mem_data_i;
            mem_q[load_ptr].rd_wdata <= rsp_rd_data_i;
            mem_q[load_ptr].data_ok  <= 1'b1;
        end
    end

    assign head_entry_o = mem_q[head_q];
    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == FULL_CNT);
    assign rsp_err_o    = rsp_valid_i && !load_found;

endmodule

// File: rtl/trace_commit_aligner.sv
// Turns raw retire records plus late in-order load data into single-cycle commit,
// memory-trace and exception records, and tracks a shadow architectural register file.
module trace_commit_aligner
    import trace_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        retire_valid,
    output logic        retire_ready,
    input  logic [31:0] retire_inst,
    input  logic [31:0] retire_pc,
    input  logic [31:0] retire_next_pc,
    input  logic [4:0]  retire_rd_addr,
    input  logic [31:0] retire_rd_wdata,
    input  logic        retire_is_load,
    input  logic        retire_is_store,
    input  logic [31:0] retire_mem_addr,
    input  logic [6:0]  retire_mem_width,
    input  logic [31:0] retire_store_data,
    input  logic        retire_trap,
    input  logic [31:0] retire_trap_cause,
    input  logic        load_rsp_valid,
    input  logic [31:0] load_rsp_mem_data,
    input  logic [31:0] load_rsp_rd_data,
    output logic        instCommit_valid,
    output logic [31:0] instCommit_inst,
    output logic [31:0] instCommit_pc,
    output logic [31:0] result_reg_0,  output logic [31:0] result_reg_1,
    output logic [31:0] result_reg_2,  output logic [31:0] result_reg_3,
    output logic [31:0] result_reg_4,  output logic [31:0] result_reg_5,
    output logic [31:0] result_reg_6,  output logic [31:0] result_reg_7,
    output logic [31:0] result_reg_8,  output logic [31:0] result_reg_9,
    output logic [31:0] result_reg_10, output logic [31:0] result_reg_11,
    output logic [31:0] result_reg_12, output logic [31:0] result_reg_13,
    output logic [31:0] result_reg_14, output logic [31:0] result_reg_15,
    output logic [31:0] result_reg_16, output logic [31:0] result_reg_17,
    output logic [31:0] result_reg_18, output logic [31:0] result_reg_19,
    output logic [31:0] result_reg_20, output logic [31:0] result_reg_21,
    output logic [31:0] result_reg_22, output logic [31:0] result_reg_23,
    output logic [31:0] result_reg_24, output logic [31:0] result_reg_25,
    output logic [31:0] result_reg_26, output logic [31:0] result_reg_27,
    output logic [31:0] result_reg_28, output logic [31:0] result_reg_29,
    output logic [31:0] result_reg_30, output logic [31:0] result_reg_31,
    output logic [31:0] result_pc,
    output logic        mem_read_valid,
    output logic [31:0] mem_read_addr,
    output logic [6:0]  mem_read_memWidth,
    output logic [31:0] mem_read_data,
    output logic        mem_write_valid,
    output logic [31:0] mem_write_addr,
    output logic [6:0]  mem_write_memWidth,
    output logic [31:0] mem_write_data,
    output logic        event_valid,
    output logic [31:0] event_cause,
    output logic [31:0] event_exceptionPC,
    output logic [31:0] event_exceptionInst,
    output logic        proto_err
);
    retire_entry_t enq_entry;
    retire_entry_t head;
    logic          empty, full, rsp_err, push, pop;

    logic        commit_valid_q, rd_valid_q, wr_valid_q, ev_valid_q, proto_err_q;
    logic [31:0] commit_inst_q, commit_pc_q, result_pc_q;
    logic [31:0] rd_addr_q, rd_data_q, wr_addr_q, wr_data_q;
    mem_width_t  rd_width_q, wr_width_q;
    logic [31:0] ev_cause_q, ev_pc_q, ev_inst_q;
    logic [31:0] regs_q [32];

    always_comb begin
        enq_entry            = '0;
        enq_entry.inst       = retire_inst;
        enq_entry.pc         = retire_pc;
        enq_entry.next_pc    = retire_next_pc;
        enq_entry.rd_addr    = retire_rd_addr;
        enq_entry.rd_wdata   = retire_rd_wdata;
        enq_entry.is_load    = retire_is_load;
        enq_entry.is_store   = retire_is_store;
        enq_entry.mem_addr   = retire_mem_addr;
        enq_entry.mem_width  = retire_mem_width;
        enq_entry.store_data = retire_store_data;
        enq_entry.trap       = retire_trap;
        enq_entry.trap_cause = retire_trap_cause;
        enq_entry.data_ok    = !waits_for_load(enq_entry);
    end

    // Ready depends only on registered occupancy; a same-cycle pop does not free a slot early.
    assign retire_ready = !full;
    assign push         = retire_valid && !full;
    assign pop          = !empty && head.data_ok;

    trace_retire_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock          (clock),
        .reset          (reset),
        .push_i         (push),
        .push_entry_i   (enq_entry),
        .pop_i          (pop),
        .rsp_valid_i    (load_rsp_valid),
        .rsp_mem_data_i (load_rsp_mem_data),
        .rsp_rd_data_i  (load_rsp_rd_data),
        .head_entry_o   (head),
        .empty_o        (empty),
        .full_o         (full),
        .rsp_err_o      (rsp_err)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_valid_q <= 1'b0;  rd_valid_q  <= 1'b0;  wr_valid_q <= 1'b0;
            ev_valid_q     <= 1'b0;  proto_err_q <= 1'b0;
            commit_inst_q  <= '0;    commit_pc_q <= '0;    result_pc_q <= RESET_PC;
            rd_addr_q      <= '0;    rd_data_q   <= '0;    rd_width_q  <= '0;
            wr_addr_q      <= '0;    wr_data_q   <= '0;    wr_width_q  <= '0;
            ev_cause_q     <= '0;    ev_pc_q     <= '0;    ev_inst_q   <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            commit_valid_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            wr_valid_q     <= 1'b0;
            ev_valid_q     <= 1'b0;
            if (rsp_err) proto_err_q <= 1'b1;
            if (pop) begin
                result_pc_q <= head.next_pc;
                if (head.trap) begin
                    ev_valid_q <= 1'b1;
                    ev_cause_q <= head.trap_cause;
                    ev_pc_q    <= head.pc;
                    ev_inst_q  <= head.inst;
                end else begin
                    commit_valid_q <= 1'b1;
                    commit_inst_q  <= head.inst;
                    commit_pc_q    <= head.pc;
                    // For loads rd_wdata was overwritten with the extended response value.
                    if (head.rd_addr != 5'd0) regs_q[head.rd_addr] <= head.rd_wdata;
                    if (head.is_load) begin
                        rd_valid_q <= 1'b1;
                        rd_addr_q  <= head.mem_addr;
                        rd_width_q <= head.mem_width;
                        rd_data_q  <= head.mem_data;
                    end
                    if (head.is_store) begin
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= head.mem_addr;
                        wr_width_q <= head.mem_width;
                        wr_data_q  <= head.store_data;
                    end
                end
            end
        end
    end

    assign instCommit_valid    = commit_valid_q;
    assign instCommit_inst     = commit_inst_q;
    assign instCommit_pc       = commit_pc_q;
    assign result_pc           = result_pc_q;
    assign mem_read_valid      = rd_valid_q;
    assign mem_read_addr       = rd_addr_q;
    assign mem_read_memWidth   = rd_width_q;
    assign mem_read_data       = rd_data_q;
    assign mem_write_valid     = wr_valid_q;
    assign mem_write_addr      = wr_addr_q;
    assign mem_write_memWidth  = wr_width_q;
    assign mem_write_data      = wr_data_q;
    assign event_valid         = ev_valid_q;
    assign event_cause         = ev_cause_q;
    assign event_exceptionPC   = ev_pc_q;
    assign event_exceptionInst = ev_inst_q;
    assign proto_err           = proto_err_q;

    assign result_reg_0  = regs_q[0];  assign result_reg_1  = regs_q[1];
    assign result_reg_2  = regs_q[2];  assign result_reg_3  = regs_q[3];
    assign result_reg_4  = regs_q[4];  assign result_reg_5  = regs_q[5];
    assign result_reg_6  = regs_q[6];  assign result_reg_7  = regs_q[7];
    assign result_reg_8  = regs_q[8];  assign result_reg_9  = regs_q[9];
    assign result_reg_10 = regs_q[10]; assign result_reg_11 = regs_q[11];
    assign result_reg_12 = regs_q[12]; assign result_reg_13 = regs_q[13];
    assign result_reg_14 = regs_q[14]; assign result_reg_15 = regs_q[15];
    assign result_reg_16 = regs_q[16]; assign result_reg_17 = regs_q[17];
    assign result_reg_18 = regs_q[18]; assign result_reg_19 = regs_q[19];
    assign result_reg_20 = regs_q[20]; assign result_reg_21 = regs_q[21];
    assign result_reg_22 = regs_q[22]; assign result_reg_23 = regs_q[23];
    assign result_reg_24 = regs_q[24]; assign result_reg_25 = regs_q[25];
    assign result_reg_26 = regs_q[26]; assign result_reg_27 = regs_q[27];
    assign result_reg_28 = regs_q[28]; assign result_reg_29 = regs_q[29];
    assign result_reg_30 = regs_q[30]; assign result_reg_31 = regs_q[31];

endmodule

// File: tb/tb_trace_commit_aligner.sv
// Bench for trace_commit_aligner: directed latency/ordering/boundary scenarios and a
// randomized run against an in-order record queue model.
module tb_trace_commit_aligner;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h8000_0000;

    typedef struct {
        logic [31:0] inst, pc, next_pc, wdata, addr, sdata, cause, mdata, rdata;
        logic [4:0]  rd;
        logic [6:0]  width;
        bit          is_load, is_store, trap, has_data;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        retire_valid, retire_ready;
    logic [31:0] retire_inst, retire_pc, retire_next_pc, retire_rd_wdata;
    logic [4:0]  retire_rd_addr;
    logic        retire_is_load, retire_is_store, retire_trap;
    logic [31:0] retire_mem_addr, retire_store_data, retire_trap_cause;
    logic [6:0]  retire_mem_width;
    logic        load_rsp_valid;
    logic [31:0] load_rsp_mem_data, load_rsp_rd_data;
    logic        instCommit_valid;
    logic [31:0] instCommit_inst, instCommit_pc, result_pc;
    logic        mem_read_valid, mem_write_valid, event_valid, proto_err;
    logic [31:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;
    logic [6:0]  mem_read_memWidth, mem_write_memWidth;
    logic [31:0] event_cause, event_exceptionPC, event_exceptionInst;
    logic [31:0] rg0,  rg1,  rg2,  rg3,  rg4,  rg5,  rg6,  rg7;
    logic [31:0] rg8,  rg9,  rg10, rg11, rg12, rg13, rg14, rg15;
    logic [31:0] rg16, rg17, rg18, rg19, rg20, rg21, rg22, rg23;
    logic [31:0] rg24, rg25, rg26, rg27, rg28, rg29, rg30, rg31;

    int n_pass  = 0;
    int n_total = 0;

    trace_commit_aligner #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset),
        .retire_valid(retire_valid), .retire_ready(retire_ready),
        .retire_inst(retire_inst), .retire_pc(retire_pc), .retire_next_pc(retire_next_pc),
        .retire_rd_addr(retire_rd_addr), .retire_rd_wdata(retire_rd_wdata),
        .retire_is_load(retire_is_load), .retire_is_store(retire_is_store),
        .retire_mem_addr(retire_mem_addr), .retire_mem_width(retire_mem_width),
        .retire_store_data(retire_store_data),
        .retire_trap(retire_trap), .retire_trap_cause(retire_trap_cause),
        .load_rsp_valid(load_rsp_valid), .load_rsp_mem_data(load_rsp_mem_data),
        .load_rsp_rd_data(load_rsp_rd_data),
        .instCommit_valid(instCommit_valid), .instCommit_inst(instCommit_inst),
        .instCommit_pc(instCommit_pc),
        .result_reg_0(rg0),   .result_reg_1(rg1),   .result_reg_2(rg2),   .result_reg_3(rg3),
        .result_reg_4(rg4),   .result_reg_5(rg5),   .result_reg_6(rg6),   .result_reg_7(rg7),
        .result_reg_8(rg8),   .result_reg_9(rg9),   .result_reg_10(rg10), .result_reg_11(rg11),
        .result_reg_12(rg12), .result_reg_13(rg13), .result_reg_14(rg14), .result_reg_15(rg15),
        .result_reg_16(rg16), .result_reg_17(rg17), .result_reg_18(rg18), .result_reg_19(rg19),
        .result_reg_20(rg20), .result_reg_21(rg21), .result_reg_22(rg22), .result_reg_23(rg23),
        .result_reg_24(rg24), .result_reg_25(rg25), .result_reg_26(rg26), .result_reg_27(rg27),
        .result_reg_28(rg28), .result_reg_29(rg29), .result_reg_30(rg30), .result_reg_31(rg31),
        .result_pc(result_pc),
        .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
        .mem_read_memWidth(mem_read_memWidth), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
        .mem_write_memWidth(mem_write_memWidth), .mem_write_data(mem_write_data),
        .event_valid(event_valid), .event_cause(event_cause),
        .event_exceptionPC(event_exceptionPC), .event_exceptionInst(event_exceptionInst),
        .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rr(input int i);
        case (i)
            0:  return rg0;   1: return rg1;   2: return rg2;   3: return rg3;
            4:  return rg4;   5: return rg5;   6: return rg6;   7: return rg7;
            8:  return rg8;   9: return rg9;  10: return rg10; 11: return rg11;
            12: return rg12; 13: return rg13; 14: return rg14; 15: return rg15;
            16: return rg16; 17: return rg17; 18: return rg18; 19: return rg19;
            20: return rg20; 21: return rg21; 22: return rg22; 23: return rg23;
            24: return rg24; 25: return rg25; 26: return rg26; 27: return rg27;
            28: return rg28; 29: return rg29; 30: return rg30; default: return rg31;
        endcase
    endfunction

    function automatic rec_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                input logic [31:0] wdata, input bit ld, input bit st,
                                input bit trap, input logic [31:0] addr);
        rec_t r;
        r.inst = $urandom; r.pc = pc; r.next_pc = pc + 32'd4; r.rd = rd; r.wdata = wdata;
        r.is_load = ld; r.is_store = st; r.trap = trap; r.addr = addr; r.width = 7'd32;
        r.sdata = $urandom; r.cause = 32'd0; r.mdata = 32'd0; r.rdata = 32'd0;
        r.has_data = !(ld && !trap);
        return r;
    endfunction

    task automatic drive(input rec_t r);
        retire_valid = 1'b1; retire_inst = r.inst; retire_pc = r.pc; retire_next_pc = r.next_pc;
        retire_rd_addr = r.rd; retire_rd_wdata = r.wdata; retire_is_load = r.is_load;
        retire_is_store = r.is_store; retire_mem_addr = r.addr; retire_mem_width = r.width;
        retire_store_data = r.sdata; retire_trap = r.trap; retire_trap_cause = r.cause;
    endtask

    task automatic respond(input logic [31:0] md, input logic [31:0] rd);
        load_rsp_valid = 1'b1; load_rsp_mem_data = md; load_rsp_rd_data = rd;
    endtask

    task automatic idle();
        retire_valid = 1'b0; load_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle(); drive(mk(32'h0, 5'd0, 32'h0, 0, 0, 0, 32'h0)); retire_valid = 1'b0;
        respond(32'h0, 32'h0); load_rsp_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_total++; if (instCommit_valid !== 1'b0) $display("FAIL reset_commit_valid: got %b want 0", instCommit_valid); else n_pass++;
        n_total++; if (result_pc !== RPC) $display("FAIL reset_result_pc: got %h want %h", result_pc, RPC); else n_pass++;
        n_total++; if (retire_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", retire_ready); else n_pass++;
        n_total++; if ({mem_read_valid, mem_write_valid, event_valid, proto_err} !== 4'b0)
            $display("FAIL reset_strobes: got %b want 0000", {mem_read_valid, mem_write_valid, event_valid, proto_err}); else n_pass++;
        n_total++; if (rr(5) !== 32'd0) $display("FAIL reset_reg5: got %h want 0", rr(5)); else n_pass++;
    endtask

    task automatic test_addi();
        rec_t r = mk(32'h100, 5'd5, 32'd7, 0, 0, 0, 32'h0);
        drive(r);
        @(negedge clock); idle();
        n_total++; if (instCommit_valid !== 1'b0) $display("FAIL addi_early: got %b want 0", instCommit_valid); else n_pass++;
        @(negedge clock);
        n_total++; if (instCommit_valid !== 1'b1 || instCommit_pc !== 32'h100 || instCommit_inst !== r.inst)
            $display("FAIL addi_commit: got v=%b pc=%h want v=1 pc=00000100", instCommit_valid, instCommit_pc); else n_pass++;
        n_total++; if (rr(5) !== 32'd7) $display("FAIL addi_reg5: got %h want 7", rr(5)); else n_pass++;
        n_total++; if (result_pc !== 32'h104) $display("FAIL addi_result_pc: got %h want 104", result_pc); else n_pass++;
        @(negedge clock);
        n_total++; if (instCommit_valid !== 1'b0) $display("FAIL addi_single_cycle: got %b want 0", instCommit_valid); else n_pass++;
    endtask

    task automatic test_load();
        drive(mk(32'h200, 5'd6, 32'h1234, 1, 0, 0, 32'h100));
        @(negedge clock); idle();
        repeat (2) @(negedge clock);
        respond(32'hDEAD_BEEF, 32'hDEAD_BEEF);
        @(negedge clock); idle();
        n_total++; if (instCommit_valid !== 1'b0) $display("FAIL load_no_bypass: got %b want 0", instCommit_valid); else n_pass++;
        @(negedge clock);
        n_total++; if (instCommit_valid !== 1'b1 || mem_read_valid !== 1'b1 || mem_read_addr !== 32'h100 ||
                       mem_read_data !== 32'hDEAD_BEEF || mem_read_memWidth !== 7'd32)
            $display("FAIL load_commit: got v=%b rv=%b addr=%h data=%h want 1 1 00000100 deadbeef",
                     instCommit_valid, mem_read_valid, mem_read_addr, mem_read_data); else n_pass++;
        n_total++; if (rr(6) !== 32'hDEAD_BEEF) $display("FAIL load_reg6: got %h want deadbeef", rr(6)); else n_pass++;
    endtask

    task automatic test_order();
        rec_t seq [3];
        logic [31:0] pcs [$];
        bit early = 0;
        seq[0] = mk(32'h300, 5'd7, 32'h0, 1, 0, 0, 32'h40);
        seq[1] = mk(32'h304, 5'd8, 32'h55, 0, 0, 0, 32'h0);
        seq[2] = mk(32'h308, 5'd9, 32'h0, 1, 0, 0, 32'h44);
        for (int c = 0; c < 12; c++) begin
            idle();
            if (c < 3) drive(seq[c]);
            if (c == 3) respond(32'hA, 32'hA);
            if (c == 4) respond(32'hB, 32'hB);
            @(negedge clock);
            if (instCommit_valid === 1'b1) begin
                pcs.push_back(instCommit_pc);
                if (c <= 3) early = 1;
            end
        end
        idle();
        n_total++; if (early) $display("FAIL order_held: got commit before first response want none"); else n_pass++;
        n_total++; if (pcs.size() != 3 || pcs[0] !== 32'h300 || pcs[1] !== 32'h304 || pcs[2] !== 32'h308)
            $display("FAIL order_seq: got %0d commits first pc %h want 3 commits 300,304,308",
                     pcs.size(), (pcs.size() > 0) ? pcs[0] : 32'h0); else n_pass++;
        n_total++; if (rr(7) !== 32'hA || rr(8) !== 32'h55 || rr(9) !== 32'hB)
            $display("FAIL order_regs: got %h %h %h want a 55 b", rr(7), rr(8), rr(9)); else n_pass++;
    endtask

    task automatic test_trap();
        rec_t r = mk(32'h400, 5'd5, 32'h999, 0, 0, 1, 32'h0);
        r.cause = 32'd2; r.next_pc = 32'h8000_0100;
        drive(r);
        @(negedge clock); idle();
        @(negedge clock);
        n_total++; if (event_valid !== 1'b1 || event_cause !== 32'd2 || event_exceptionPC !== 32'h400 ||
                       event_exceptionInst !== r.inst || instCommit_valid !== 1'b0)
            $display("FAIL trap_event: got ev=%b cause=%h epc=%h cv=%b want 1 2 400 0",
                     event_valid, event_cause, event_exceptionPC, instCommit_valid); else n_pass++;
        n_total++; if (rr(5) !== 32'd7) $display("FAIL trap_reg5: got %h want 7", rr(5)); else n_pass++;
        n_total++; if (result_pc !== 32'h8000_0100) $display("FAIL trap_result_pc: got %h want 80000100", result_pc); else n_pass++;
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            drive(mk(32'h500 + 32'(i * 4), 5'(10 + i), 32'h0, 1, 0, 0, 32'h80 + 32'(i * 4)));
            @(negedge clock);
        end
        drive(mk(32'h600, 5'd20, 32'h66, 0, 0, 0, 32'h0));
        n_total++; if (retire_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", retire_ready); else n_pass++;
        @(negedge clock);
        retire_valid = 1'b0;
        respond(32'h10, 32'h10);
        @(negedge clock); idle();
        n_total++; if (retire_ready !== 1'b0) $display("FAIL full_ready_pop_cycle: got %b want 0", retire_ready); else n_pass++;
        @(negedge clock);
        n_total++; if (retire_ready !== 1'b1 || instCommit_valid !== 1'b1)
            $display("FAIL full_ready_after_pop: got ready=%b cv=%b want 1 1", retire_ready, instCommit_valid); else n_pass++;
        for (int i = 1; i < DEPTH; i++) begin
            respond(32'h10 + 32'(i), 32'h10 + 32'(i));
            @(negedge clock);
        end
        idle();
        repeat (3) @(negedge clock);
        n_total++; if (rr(13) !== 32'h13 || rr(20) !== 32'd0 || proto_err !== 1'b0)
            $display("FAIL full_drain: got r13=%h r20=%h perr=%b want 13 0 0", rr(13), rr(20), proto_err); else n_pass++;
    endtask

    task automatic test_proto_err();
        respond(32'h1, 32'h1);
        @(negedge clock); idle();
        n_total++; if (proto_err !== 1'b1) $display("FAIL perr_set: got %b want 1", proto_err); else n_pass++;
        repeat (3) @(negedge clock);
        n_total++; if (proto_err !== 1'b1) $display("FAIL perr_sticky: got %b want 1", proto_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(mk(32'h700, 5'd11, 32'h77, 0, 0, 0, 32'h0));
        @(negedge clock);
        drive(mk(32'h704, 5'd12, 32'h0, 1, 0, 0, 32'h90));
        @(negedge clock);
        drive(mk(32'h708, 5'd13, 32'h0, 1, 0, 0, 32'h94));
        @(negedge clock); idle();
        n_total++; if (rr(11) !== 32'h77) $display("FAIL mid_pre_reg11: got %h want 77", rr(11)); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (instCommit_pc !== 32'h0 || result_pc !== RPC || rr(11) !== 32'h0 || proto_err !== 1'b0 || retire_ready !== 1'b1)
            $display("FAIL mid_reset: got pc=%h rpc=%h r11=%h perr=%b rdy=%b want 0 %h 0 0 1",
                     instCommit_pc, result_pc, rr(11), proto_err, retire_ready, RPC); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        respond(32'h5, 32'h5);
        @(negedge clock); idle();
        n_total++; if (proto_err !== 1'b1) $display("FAIL mid_stale_rsp: got %b want 1", proto_err); else n_pass++;
    endtask

    task automatic test_random();
        rec_t        q [$];
        rec_t        e, r;
        logic [31:0] mregs [32];
        logic [31:0] mpc = RPC;
        int          pend = 0;
        int          kind;
        bit          ok;
        idle();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clock);
            if (instCommit_valid === 1'b1 || event_valid === 1'b1) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL rand_unexpected: got record pc %h want none", instCommit_pc);
                end else begin
                    e  = q.pop_front();
                    ok = 1;
                    if (e.trap) begin
                        ok = (event_valid === 1'b1) && (instCommit_valid === 1'b0) && (event_cause === e.cause) &&
                             (event_exceptionPC === e.pc) && (event_exceptionInst === e.inst) &&
                             (mem_read_valid === 1'b0) && (mem_write_valid === 1'b0);
                    end else begin
                        ok = (instCommit_valid === 1'b1) && (event_valid === 1'b0) && (instCommit_pc === e.pc) &&
                             (instCommit_inst === e.inst) && (mem_read_valid === e.is_load) &&
                             (mem_write_valid === e.is_store);
                        if (e.is_load)
                            ok = ok && (mem_read_addr === e.addr) && (mem_read_memWidth === e.width) && (mem_read_data === e.mdata);
                        if (e.is_store)
                            ok = ok && (mem_write_addr === e.addr) && (mem_write_memWidth === e.width) && (mem_write_data === e.sdata);
                        if (e.rd != 5'd0) mregs[e.rd] = e.is_load ? e.rdata : e.wdata;
                    end
                    mpc = e.next_pc;
                    ok  = ok && (result_pc === mpc) && (rr(int'(e.rd)) === mregs[e.rd]) && (rr(0) === 32'd0);
                    if (!ok)
                        $display("FAIL rand_commit: got pc=%h cv=%b ev=%b rpc=%h reg=%h want pc=%h trap=%b rpc=%h reg=%h",
                                 e.trap ? event_exceptionPC : instCommit_pc, instCommit_valid, event_valid,
                                 result_pc, rr(int'(e.rd)), e.pc, e.trap, mpc, mregs[e.rd]);
                    else n_pass++;
                end
            end
            idle();
            if (pend > 0 && $urandom_range(0, 1) == 1) begin
                respond($urandom, $urandom);
                foreach (q[k]) begin
                    if (q[k].is_load && !q[k].trap && !q[k].has_data) begin
                        q[k].mdata = load_rsp_mem_data; q[k].rdata = load_rsp_rd_data; q[k].has_data = 1;
                        break;
                    end
                end
                pend--;
            end
            if (cyc < 500 && $urandom_range(0, 3) != 0) begin
                kind = $urandom_range(0, 9);
                r = mk($urandom, 5'($urandom_range(0, 31)), $urandom, kind inside {[4:6]}, kind inside {[7:8]},
                       kind == 9, $urandom);
                if (kind == 9) begin
                    r.cause = $urandom_range(0, 15); r.is_load = $urandom_range(0, 1); r.next_pc = $urandom;
                    r.has_data = 1;
                end
                r.width = 7'($urandom_range(0, 127));
                drive(r);
                if (retire_ready === 1'b1) begin
                    q.push_back(r);
                    if (r.is_load && !r.trap) pend++;
                end
            end
        end
        idle();
        n_total++; if (q.size() != 0) $display("FAIL rand_drain: got %0d records left want 0", q.size()); else n_pass++;
        n_total++; if (proto_err !== 1'b0) $display("FAIL rand_proto_err: got %b want 0", proto_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load();
        test_order();
        test_trap();
        test_full();
        test_proto_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
